// File: rtl/sipo_frame_ctrl_if.sv
// Word-side bus of the SIPO frame controller: shift-register control/data and the
// one-entry output buffer handshake.
interface sipo_frame_ctrl_if #(
  parameter int unsigned OUTPUT_WIDTH = 8
) ();

  logic                    sr_shift;
  logic                    sr_clear;
  logic                    sr_latch;
  logic [OUTPUT_WIDTH-1:0] sr_data;
  logic [OUTPUT_WIDTH-1:0] out_data;
  logic                    out_valid;
  logic                    out_ready;

  modport master (
    output sr_shift,
    output sr_clear,
    output sr_latch,
    output out_data,
    output out_valid,
    input  sr_data,
    input  out_ready
  );

  modport slave (
    input  sr_shift,
    input  sr_clear,
    input  sr_latch,
    input  out_data,
    input  out_valid,
    output sr_data,
    output out_ready
  );

endinterface

// File: rtl/sipo_frame_ctrl.sv
// Frame sequencer for an external serial-in parallel-out shift register: counts bit
// strobes, pulses clear/latch, and captures the latched word into a valid/ready buffer.
module sipo_frame_ctrl #(
  parameter int unsigned OUTPUT_WIDTH   = 8,
  parameter int unsigned TIMEOUT_CYCLES = 0,
  parameter int unsigned CONTINUOUS     = 0
) (
  input  logic                               clk_i,
  input  logic                               reset_i,
  input  logic                               enable_i,
  input  logic                               frame_start_i,
  input  logic                               bit_strobe_i,
  input  logic                               overrun_clr_i,
  sipo_frame_ctrl_if.master                  bus_io,
  output logic                               busy_o,
  output logic [$clog2(OUTPUT_WIDTH+1)-1:0]  bit_count_o,
  output logic                               timeout_err_o,
  output logic                               overrun_o
);

  localparam int unsigned CntW = $clog2(OUTPUT_WIDTH + 1);
  localparam int unsigned GapW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CntW-1:0] LastBit  = CntW'(OUTPUT_WIDTH - 1);
  localparam logic [CntW-1:0] FullCnt  = CntW'(OUTPUT_WIDTH);
  localparam logic [GapW-1:0] GapLimit = GapW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {StIdle, StShift, StLatch, StCapture} state_e;

  state_e                  state_q, state_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [GapW-1:0]         gap_q, gap_d;
  logic                    clear_q, clear_d;
  logic                    latch_q, latch_d;
  logic                    terr_q, terr_d;
  logic                    overrun_q, overrun_d;
  logic                    out_valid_q, out_valid_d;
  logic [OUTPUT_WIDTH-1:0] out_data_q, out_data_d;
  logic                    shift;
  logic                    capture_ok;
  logic                    capture_drop;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    gap_d        = gap_q;
    clear_d      = 1'b0;
    terr_d       = 1'b0;
    shift        = 1'b0;
    capture_ok   = 1'b0;
    capture_drop = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (enable_i && frame_start_i) begin
          state_d = StShift;
          clear_d = 1'b1;
          cnt_d   = '0;
          gap_d   = '0;
        end
      end
      StShift: begin
        if (!enable_i) begin
          state_d = StIdle;
          cnt_d   = '0;
          gap_d   = '0;
        end else if (frame_start_i) begin
          // Restart takes precedence over a coincident strobe.
          clear_d = 1'b1;
          cnt_d   = '0;
          gap_d   = '0;
        end else if (bit_strobe_i) begin
          shift = 1'b1;
          gap_d = '0;
          if (cnt_q == LastBit) begin
            cnt_d   = FullCnt;
            state_d = StLatch;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else if (TIMEOUT_CYCLES > 0) begin
          if (gap_q >= GapLimit - 1'b1) begin
            state_d = StIdle;
            terr_d  = 1'b1;
            cnt_d   = '0;
            gap_d   = '0;
          end else begin
            gap_d = gap_q + 1'b1;
          end
        end
      end
      StLatch: begin
        if (!enable_i) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          state_d = StCapture;
        end
      end
      StCapture: begin
        if (!enable_i) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          if (!out_valid_q || bus_io.out_ready) begin
            capture_ok = 1'b1;
          end else begin
            capture_drop = 1'b1;
          end
          cnt_d = '0;
          gap_d = '0;
          if (CONTINUOUS != 0) begin
            state_d = StShift;
            clear_d = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    latch_d = (state_d == StLatch);

    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (out_valid_q && bus_io.out_ready) begin
      out_valid_d = 1'b0;
    end
    if (capture_ok) begin
      out_valid_d = 1'b1;
      out_data_d  = bus_io.sr_data;
    end

    overrun_d = overrun_q;
    if (overrun_clr_i) begin
      overrun_d = 1'b0;
    end
    if (capture_drop) begin
      overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      gap_q       <= '0;
      clear_q     <= 1'b0;
      latch_q     <= 1'b0;
      terr_q      <= 1'b0;
      overrun_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      gap_q       <= gap_d;
      clear_q     <= clear_d;
      latch_q     <= latch_d;
      terr_q      <= terr_d;
      overrun_q   <= overrun_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign bus_io.sr_shift  = shift;
  assign bus_io.sr_clear  = clear_q;
  assign bus_io.sr_latch  = latch_q;
  assign bus_io.out_data  = out_data_q;
  assign bus_io.out_valid = out_valid_q;
  assign busy_o           = (state_q != StIdle);
  assign bit_count_o      = cnt_q;
  assign timeout_err_o    = terr_q;
  assign overrun_o        = overrun_q;

endmodule

// File: doc/sipo_frame_ctrl.md
Name: sipo_frame_ctrl

Overview:
Sequencer for a serial-in parallel-out shift register of width OUTPUT_WIDTH. It frames incoming serial bits, gates the shift register's shift and clear, and pulses its latch after exactly OUTPUT_WIDTH bits. It then captures the latched word into a one-entry output buffer with a valid/ready handshake. It sits between a bit-level serial front end (which supplies bit strobes) and a word-level consumer.

Parameters:
OUTPUT_WIDTH, 8, bits per frame; width of sr_data/out_data; must be >= 2.
TIMEOUT_CYCLES, 0, max clk cycles allowed between bit strobes inside a frame; 0 disables the timeout.
CONTINUOUS, 0, 1 = after capture, start the next frame immediately without waiting for frame_start.

Ports:
clk  input  1  single clock; all state is updated on the rising edge.
reset  input  1  synchronous, active-high reset.
enable  input  1  block enable; low aborts any frame in progress.
frame_start  input  1  one-cycle pulse that begins (or restarts) a frame.
bit_strobe  input  1  serial bit valid this cycle.
sr_shift  output  1  shift enable to the shift register; combinational.
sr_clear  output  1  one-cycle clear pulse to the shift register; registered.
sr_latch  output  1  one-cycle latch pulse to the shift register; registered.
sr_data  input  OUTPUT_WIDTH  latched parallel word from the shift register.
out_data  output  OUTPUT_WIDTH  buffered word.
out_valid  output  1  out_data holds an unconsumed word.
out_ready  input  1  consumer accepts the word when out_valid is high.
busy  output  1  state is not IDLE.
bit_count  output  $clog2(OUTPUT_WIDTH+1)  bits shifted in the current frame.
timeout_err  output  1  one-cycle pulse when a frame is dropped on timeout.
overrun  output  1  sticky flag: a captured word was dropped because the buffer was full.
overrun_clr  input  1  clears overrun.

Behaviour:
- Reset (synchronous, active-high, priority over everything):
  - state = IDLE; bit_count, gap counter = 0.
  - sr_clear, sr_latch, out_valid, timeout_err, overrun = 0; out_data = 0.
- States are IDLE, SHIFT, LATCH, CAPTURE.
- IDLE:
  - enable & frame_start -> SHIFT; sr_clear = 1 next cycle; bit_count = 0.
  - bit_strobe is ignored and sr_shift = 0.
- SHIFT:
  - sr_shift = bit_strobe & enable, same cycle (combinational).
  - Each strobe increments bit_count and zeroes the gap counter.
  - A strobe while bit_count == OUTPUT_WIDTH-1 -> LATCH, with bit_count = OUTPUT_WIDTH.
- SHIFT, gap timeout:
  - With TIMEOUT_CYCLES > 0, the gap counter increments on each non-strobe cycle.
  - When it reaches TIMEOUT_CYCLES -> IDLE; timeout_err pulses for 1 cycle; no latch; bit_count = 0.
- SHIFT, frame_start:
  - Restarts the frame: sr_clear pulse, bit_count = 0, gap counter = 0, no error.
  - frame_start and bit_strobe in the same cycle: the restart wins and the strobe is not shifted (sr_shift = 0).
- LATCH:
  - sr_latch = 1 for exactly this one cycle -> CAPTURE.
  - bit_strobe is ignored; frame_start is ignored.
- CAPTURE: sample sr_data.
  - If out_valid == 0 or out_ready == 1 this cycle: out_data <= sr_data and out_valid <= 1.
  - Otherwise: the word is dropped, overrun <= 1, and the buffer is unchanged.
  - Next state: CONTINUOUS=1 & enable -> SHIFT (with sr_clear pulse, bit_count = 0); else -> IDLE.
- Latency: last strobe in cycle T -> sr_latch high in T+1 -> capture in T+2 -> out_valid high from T+3.
- Output handshake:
  - A transfer occurs on out_valid & out_ready.
  - out_valid falls the next cycle unless reloaded in the same cycle (back-to-back allowed).
  - out_data is stable while out_valid & !out_ready.
- overrun: set has priority over overrun_clr in the same cycle.
- enable low in SHIFT/LATCH/CAPTURE:
  - Next state IDLE, bit_count = 0, no latch, no capture, no error.
  - The output buffer and handshake continue unaffected.
- busy = (state != IDLE).
- bit_count saturates at OUTPUT_WIDTH; the gap counter saturates at TIMEOUT_CYCLES.

Test Plan:
- Basic frame: OUTPUT_WIDTH=8; frame_start, then 8 strobes of pattern 0xA5 on consecutive cycles -> exactly 8 sr_shift pulses; sr_latch 1 cycle after the 8th; out_valid 3 cycles after the 8th, out_data=0xA5; bit_count reads 8 in LATCH.
- Backpressure/overrun: out_ready=0, two complete frames 0x3C then 0xC3 -> out_data stays 0x3C; overrun=1 after the 2nd capture; overrun_clr -> 0; ready=1 -> a single transfer of 0x3C.
- Timeout: TIMEOUT_CYCLES=4; 5 strobes, then a 4-cycle gap -> timeout_err pulses once; state IDLE; no sr_latch; out_valid unchanged.
- Restart/abort: frame_start after 3 strobes -> sr_clear pulses, bit_count=0, 8 more strobes required for a latch; enable=0 after 6 strobes -> IDLE next cycle, no sr_latch.
- Reset mid-frame: reset asserted after 5 strobes with out_valid=1 -> next edge all outputs 0, state IDLE; strobes ignored until frame_start.
- CONTINUOUS=1: 16 consecutive strobes after a single frame_start -> two captured words, with no strobe accepted in LATCH/CAPTURE cycles (sr_shift=0 there).
